// File: rtl/brq_pmp_arb.sv
// Round-robin arbiter sharing one PMP check channel between NumReq requesters, with a
// registered, index-tagged response. Optional fault counter: define BRQ_PMP_ARB_ERRCNT_EN.
module brq_pmp_arb #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0][33:0]       req_addr_i,
  input  logic [NumReq-1:0][1:0]        req_type_i,
  input  logic [NumReq-1:0][1:0]        req_priv_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [33:0]                   pmp_req_addr_o,
  output logic [1:0]                    pmp_req_type_o,
  output logic [1:0]                    pmp_priv_mode_o,
  input  logic                          pmp_req_err_i,
  output logic                          rsp_valid_o,
  output logic [IdxW-1:0]               rsp_id_o,
  output logic                          rsp_err_o,
  input  logic                          rsp_ready_i,
  output logic [15:0]                   err_cnt_o,
  input  logic                          err_cnt_clr_i
);

  logic            rsp_valid_q;
  logic [IdxW-1:0] rsp_id_q;
  logic            rsp_err_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] rr_ptr_d;

  logic            accept;
  logic            any_valid;
  logic            handshake;
  logic [IdxW-1:0] gnt_idx;
  logic            found;
  logic [IdxW:0]   cand;

  assign accept    = ~rsp_valid_q | rsp_ready_i;
  assign any_valid = |req_valid_i;
  assign handshake = accept & any_valid;

  // Search from rr_ptr upward with wrap; with nothing valid gnt_idx stays at rr_ptr so the
  // PMP drive is deterministic.
  always_comb begin
    gnt_idx = rr_ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) begin
        cand = cand - (IdxW+1)'(NumReq);
      end
      if (!found && req_valid_i[cand[IdxW-1:0]]) begin
        gnt_idx = cand[IdxW-1:0];
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (handshake) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign pmp_req_addr_o  = req_addr_i[gnt_idx];
  assign pmp_req_type_o  = req_type_i[gnt_idx];
  assign pmp_priv_mode_o = req_priv_i[gnt_idx];

  assign rr_ptr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

  // Response register doubles as the IDLE/RESP state: rsp_valid_q is the state bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else if (accept) begin
      rsp_valid_q <= any_valid;
      if (any_valid) begin
        rsp_id_q  <= gnt_idx;
        rsp_err_q <= pmp_req_err_i;
        rr_ptr_q  <= rr_ptr_d;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;

`ifdef BRQ_PMP_ARB_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Clear has priority over a same-cycle fault; counter saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (err_cnt_clr_i) begin
      err_cnt_q <= '0;
    end else if (handshake && pmp_req_err_i && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_cnt_clr;

  assign unused_err_cnt_clr = err_cnt_clr_i;
  assign err_cnt_o          = 16'h0;
`endif

endmodule
